// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared types and constants for the DMA read/write splitters
package dma_pkg;

    // FSM encoding shared by the splitter family
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DONE  = 2'd3
    } dma_state_t;

    // 4 KB address boundary expressed in DWORDs
    localparam int LP_BOUND_DW   = 1024;
    // PCIe length field width; a value of 1024 DW is encoded as 0
    localparam int LP_PCIE_LEN_W = 10;

endpackage

// File: rtl/dma_read_splitter_if.sv
// rtl/dma_read_splitter_if.sv - command and arbiter-path bundle for the DMA read splitter
// Signals:
//   i_cmd_addr/i_cmd_len_dw/i_cmd_valid : command in (byte address, length in DW)
//   o_cmd_ready/o_cmd_done/o_busy       : command status out
//   o_read_addr/o_read_len/o_read_valid : chunk request to the arbiter path
//   i_read_done                         : chunk completion pulse from the arbiter path
// Modports: slave = splitter view, master = command source / arbiter-side view.
interface dma_read_splitter_if #(
    parameter int p_len_bits = 20
);
    logic [31:0]           i_cmd_addr;
    logic [p_len_bits-1:0] i_cmd_len_dw;
    logic                  i_cmd_valid;
    logic                  o_cmd_ready;
    logic                  o_cmd_done;
    logic                  o_busy;
    logic [31:0]           o_read_addr;
    logic [9:0]            o_read_len;
    logic                  o_read_valid;
    logic                  i_read_done;

    modport slave (
        input  i_cmd_addr, i_cmd_len_dw, i_cmd_valid, i_read_done,
        output o_cmd_ready, o_cmd_done, o_busy, o_read_addr, o_read_len, o_read_valid
    );

    modport master (
        output i_cmd_addr, i_cmd_len_dw, i_cmd_valid, i_read_done,
        input  o_cmd_ready, o_cmd_done, o_busy, o_read_addr, o_read_len, o_read_valid
    );
endinterface

// File: rtl/dma_chunk_calc.sv
// rtl/dma_chunk_calc.sv - min(remaining, max request, DW to next 4 KB boundary) chunk sizer
// Ports:
//   rem     : remaining DWORDs of the command
//   dw_off  : DWORD offset of the current address within its 4 KB page (addr[11:2])
//   chunk   : chunk length in DWORDs, 1..1024 (11 bits)
//   len_enc : chunk length in PCIe encoding (1024 -> 0)
import dma_pkg::*;

module dma_chunk_calc #(
    parameter int p_max_len_dw = 128,
    parameter int p_len_bits   = 20
) (
    input  logic [p_len_bits-1:0]    rem,
    input  logic [9:0]               dw_off,
    output logic [10:0]              chunk,
    output logic [LP_PCIE_LEN_W-1:0] len_enc
);

    logic [31:0] rem_w;
    logic [10:0] rem_c;
    logic [10:0] max_c;
    logic [10:0] bound_c;
    logic [10:0] m;

    always_comb begin
        rem_w   = 32'(rem);
        // Anything above one page can never win the min, so clamp before narrowing
        rem_c   = (rem_w > 32'(LP_BOUND_DW)) ? 11'(LP_BOUND_DW) : rem_w[10:0];
        max_c   = 11'(p_max_len_dw);
        // Range 1..1024: an aligned page start yields the full 1024
        bound_c = 11'(LP_BOUND_DW) - {1'b0, dw_off};
        m       = rem_c;
        if (max_c < m) begin
            m = max_c;
        end
        if (bound_c < m) begin
            m = bound_c;
        end
        chunk   = m;
        len_enc = m[LP_PCIE_LEN_W-1:0];
    end

endmodule

// File: rtl/dma_read_splitter.sv
// rtl/dma_read_splitter.sv - splits a large DMA read command into PCIe-legal chunks
// Ports:
//   i_clk : clock
//   i_rst : synchronous active-high reset
//   bus   : dma_read_splitter_if.slave (command in, chunk request out, completion in)
import dma_pkg::*;

module dma_read_splitter #(
    parameter int p_max_len_dw = 128,
    parameter int p_len_bits   = 20
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    dma_read_splitter_if.slave   bus
);

    dma_state_t            state;
    dma_state_t            state_nx;
    logic [31:0]           r_addr;
    logic [p_len_bits-1:0] r_rem;
    logic [10:0]           r_chunk;
    logic [31:0]           r_read_addr;
    logic [9:0]            r_read_len;
    logic [10:0]           calc_chunk;
    logic [9:0]            calc_len_enc;

    dma_chunk_calc #(
        .p_max_len_dw (p_max_len_dw),
        .p_len_bits   (p_len_bits)
    ) u_chunk_calc (
        .rem     (r_rem),
        .dw_off  (r_addr[11:2]),
        .chunk   (calc_chunk),
        .len_enc (calc_len_enc)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            r_addr      <= '0;
            r_rem       <= '0;
            r_chunk     <= '0;
            r_read_addr <= '0;
            r_read_len  <= '0;
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: begin
                    if (bus.i_cmd_valid) begin
                        r_addr <= bus.i_cmd_addr & ~32'h3;
                        r_rem  <= bus.i_cmd_len_dw;
                    end
                end
                ST_CALC: begin
                    r_chunk     <= calc_chunk;
                    r_read_addr <= r_addr;
                    r_read_len  <= calc_len_enc;
                end
                ST_ISSUE: begin
                    if (bus.i_read_done) begin
                        // Address wraps silently at 4 GB
                        r_addr <= r_addr + {19'd0, r_chunk, 2'b00};
                        r_rem  <= r_rem - p_len_bits'(r_chunk);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (bus.i_cmd_valid) begin
                    state_nx = (bus.i_cmd_len_dw == '0) ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC:  state_nx = ST_ISSUE;
            ST_ISSUE: begin
                if (bus.i_read_done) begin
                    state_nx = (r_rem == p_len_bits'(r_chunk)) ? ST_DONE : ST_CALC;
                end
            end
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    assign bus.o_cmd_ready  = (state == ST_IDLE);
    assign bus.o_busy       = (state != ST_IDLE);
    assign bus.o_cmd_done   = (state == ST_DONE);
    assign bus.o_read_valid = (state == ST_ISSUE);
    assign bus.o_read_addr  = r_read_addr;
    assign bus.o_read_len   = r_read_len;

endmodule

// File: tb/tb_dma_read_splitter.sv
// tb/tb_dma_read_splitter.sv - self-checking bench for dma_read_splitter
module tb_dma_read_splitter;

    typedef struct {
        int              sel;
        logic [31:0]     addr;
        logic [19:0]     len;
        int              n;
        int              dly;
        logic [2:0][31:0] ea;
        logic [2:0][9:0]  el;
    } vec_t;

    typedef struct packed {
        logic [31:0] a;
        logic [9:0]  l;
    } req_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] cmd_addr  = '0;
    logic [19:0] cmd_len   = '0;
    logic        cmd_valid = 1'b0;
    logic        read_done = 1'b0;
    logic        sel       = 1'b0;

    int n_run  = 0;
    int n_fail = 0;
    req_t q[$];
    vec_t vecs[8];

    dma_read_splitter_if #(.p_len_bits(20)) if0 ();
    dma_read_splitter_if #(.p_len_bits(20)) if1 ();

    dma_read_splitter #(.p_max_len_dw(128), .p_len_bits(20)) u_dut0 (
        .i_clk (clk), .i_rst (rst), .bus (if0)
    );
    dma_read_splitter #(.p_max_len_dw(1024), .p_len_bits(20)) u_dut1 (
        .i_clk (clk), .i_rst (rst), .bus (if1)
    );

    assign if0.i_cmd_addr   = cmd_addr;
    assign if1.i_cmd_addr   = cmd_addr;
    assign if0.i_cmd_len_dw = cmd_len;
    assign if1.i_cmd_len_dw = cmd_len;
    assign if0.i_cmd_valid  = cmd_valid & ~sel;
    assign if1.i_cmd_valid  = cmd_valid & sel;
    assign if0.i_read_done  = read_done & ~sel;
    assign if1.i_read_done  = read_done & sel;

    wire        obs_valid = sel ? if1.o_read_valid : if0.o_read_valid;
    wire        obs_ready = sel ? if1.o_cmd_ready  : if0.o_cmd_ready;
    wire        obs_done  = sel ? if1.o_cmd_done   : if0.o_cmd_done;
    wire        obs_busy  = sel ? if1.o_busy       : if0.o_busy;
    wire [31:0] obs_addr  = sel ? if1.o_read_addr  : if0.o_read_addr;
    wire [9:0]  obs_len   = sel ? if1.o_read_len   : if0.o_read_len;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int s, input logic [31:0] a, input logic [19:0] l,
                                input int n, input int d,
                                input logic [31:0] a0, input logic [9:0] l0,
                                input logic [31:0] a1, input logic [9:0] l1,
                                input logic [31:0] a2, input logic [9:0] l2);
        vec_t v;
        v.sel = s; v.addr = a; v.len = l; v.n = n; v.dly = d;
        v.ea[0] = a0; v.el[0] = l0;
        v.ea[1] = a1; v.el[1] = l1;
        v.ea[2] = a2; v.el[2] = l2;
        return v;
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, obs_valid, 1'b0);
        check({tag, "_ready"}, obs_ready, 1'b1);
        check({tag, "_done"},  obs_done,  1'b0);
        check({tag, "_busy"},  obs_busy,  1'b0);
        check({tag, "_addr"},  obs_addr,  32'h0);
        check({tag, "_len"},   obs_len,   10'h0);
    endtask

    task automatic run_vec(input vec_t v);
        req_t exp;
        logic [31:0] hold_addr;
        logic [9:0]  hold_len;
        sel = v.sel[0];
        @(negedge clk);
        check("ready_idle", obs_ready, 1'b1);
        for (int i = 0; i < v.n; i++) q.push_back({v.ea[i], v.el[i]});
        cmd_addr  = v.addr;
        cmd_len   = v.len;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        if (v.n == 0) begin
            check("empty_done_t1", obs_done, 1'b1);
            check("empty_no_valid", obs_valid, 1'b0);
            @(negedge clk);
            check("empty_done_once", obs_done, 1'b0);
            check("empty_ready_t2", obs_ready, 1'b1);
            check("empty_no_valid2", obs_valid, 1'b0);
            return;
        end
        check("calc_valid_low", obs_valid, 1'b0);
        check("calc_busy", obs_busy, 1'b1);
        check("calc_not_ready", obs_ready, 1'b0);
        for (int c = 0; c < v.n; c++) begin
            @(negedge clk);
            check("valid_latency", obs_valid, 1'b1);
            if (q.size() == 0) begin
                n_run++;
                n_fail++;
                $display("FAIL sb_underflow: got request %0h/%0h with none expected", obs_addr, obs_len);
            end else begin
                exp = q.pop_front();
                check("req_addr", obs_addr, exp.a);
                check("req_len", obs_len, exp.l);
            end
            hold_addr = obs_addr;
            hold_len  = obs_len;
            for (int d = 0; d < v.dly; d++) begin
                if (d == 0 && v.dly > 2) begin
                    // Stray command while busy must be ignored
                    cmd_addr  = 32'hdead_0000;
                    cmd_len   = 20'd7;
                    cmd_valid = 1'b1;
                end
                @(negedge clk);
                check("hold_valid", obs_valid, 1'b1);
                check("hold_addr", obs_addr, hold_addr);
                check("hold_len", obs_len, hold_len);
                check("hold_not_ready", obs_ready, 1'b0);
            end
            cmd_valid = 1'b0;
            read_done = 1'b1;
            @(negedge clk);
            read_done = 1'b0;
            check("valid_drop", obs_valid, 1'b0);
            check("done_pulse", obs_done, (c == v.n - 1));
        end
        @(negedge clk);
        check("done_one_cycle", obs_done, 1'b0);
        check("ready_after_done", obs_ready, 1'b1);
        check("sb_drained", q.size(), 0);
    endtask

    initial begin
        vecs[0] = mk(0, 32'h0000_1000, 20'd64,   1, 3,  32'h0000_1000, 10'd64,  32'h0, 10'd0, 32'h0, 10'd0);
        vecs[1] = mk(0, 32'h0000_0F80, 20'd100,  2, 1,  32'h0000_0F80, 10'd32,  32'h0000_1000, 10'd68, 32'h0, 10'd0);
        vecs[2] = mk(0, 32'h0000_2000, 20'd300,  3, 20, 32'h0000_2000, 10'd128, 32'h0000_2200, 10'd128, 32'h0000_2400, 10'd44);
        vecs[3] = mk(1, 32'h0000_0000, 20'd1024, 1, 0,  32'h0000_0000, 10'd0,   32'h0, 10'd0, 32'h0, 10'd0);
        vecs[4] = mk(1, 32'h0000_0004, 20'd1024, 2, 2,  32'h0000_0004, 10'd1023, 32'h0000_1000, 10'd1, 32'h0, 10'd0);
        vecs[5] = mk(0, 32'h0000_5000, 20'd0,    0, 0,  32'h0, 10'd0, 32'h0, 10'd0, 32'h0, 10'd0);
        vecs[6] = mk(0, 32'h0000_0FFF, 20'd5,    2, 0,  32'h0000_0FFC, 10'd1,   32'h0000_1000, 10'd4, 32'h0, 10'd0);
        vecs[7] = mk(0, 32'hFFFF_FF00, 20'd100,  2, 1,  32'hFFFF_FF00, 10'd64,  32'h0000_0000, 10'd36, 32'h0, 10'd0);

        repeat (3) @(negedge clk);
        sel = 1'b0;
        check_reset_state("rst0");
        sel = 1'b1;
        check_reset_state("rst1");
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Reset in the middle of an issued chunk
        sel = 1'b0;
        @(negedge clk);
        cmd_addr  = 32'h0000_3000;
        cmd_len   = 20'd64;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("midrst_pre_valid", obs_valid, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("midrst");
        read_done = 1'b1;
        @(negedge clk);
        read_done = 1'b0;
        check("stray_done_valid", obs_valid, 1'b0);
        check("stray_done_nodone", obs_done, 1'b0);
        check("stray_done_ready", obs_ready, 1'b1);
        @(negedge clk);
        check("stray_done_nodone2", obs_done, 1'b0);

        run_vec(vecs[0]);
        run_vec(vecs[1]);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
